// File: rtl/dlfloat_pkg.sv
// Shared DLFloat definitions for the MAC sequencer: word layout, special values
// and the sequencer state encoding.
package dlfloat_pkg;

  localparam int DLF_W     = 16;
  localparam int DLF_EXP_W = 6;
  localparam int DLF_MAN_W = 9;

  localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;

  localparam int DLF_SIGN_BIT = 15;
  localparam int DLF_EXP_HI   = 14;
  localparam int DLF_EXP_LO   = 9;
  localparam int DLF_MAN_HI   = 8;
  localparam int DLF_MAN_LO   = 0;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    DONE
  } seq_state_e;

  function automatic logic dlf_sign(input logic [DLF_W-1:0] x);
    return x[DLF_SIGN_BIT];
  endfunction

  function automatic logic [DLF_EXP_W-1:0] dlf_exp(input logic [DLF_W-1:0] x);
    return x[DLF_EXP_HI:DLF_EXP_LO];
  endfunction

  function automatic logic [DLF_MAN_W-1:0] dlf_man(input logic [DLF_W-1:0] x);
    return x[DLF_MAN_HI:DLF_MAN_LO];
  endfunction

  // DLFloat has a single NaN encoding (all ones).
  function automatic logic dlf_is_nan(input logic [DLF_W-1:0] x);
    return x == DLF_NAN;
  endfunction

endpackage

// File: rtl/dlfloat_mac_seq_if.sv
// Operand, datapath and result channels of the DLFloat MAC sequencer.
// master = environment (operand source, datapath, result sink); slave = sequencer.
interface dlfloat_mac_seq_if;
  import dlfloat_pkg::*;

  logic             op_valid;
  logic             op_ready;
  logic [DLF_W-1:0] op_a;
  logic [DLF_W-1:0] op_b;

  logic [DLF_W-1:0] mac_a;
  logic [DLF_W-1:0] mac_b;
  logic             mac_en;
  logic             mac_clr;
  logic [DLF_W-1:0] mac_acc;

  logic             res_valid;
  logic             res_ready;
  logic [DLF_W-1:0] res_data;

  modport master (
    output op_valid, op_a, op_b, mac_acc, res_ready,
    input  op_ready, mac_a, mac_b, mac_en, mac_clr, res_valid, res_data
  );

  modport slave (
    input  op_valid, op_a, op_b, mac_acc, res_ready,
    output op_ready, mac_a, mac_b, mac_en, mac_clr, res_valid, res_data
  );

endinterface

// File: rtl/dlfloat_mac_seq.sv
// Job sequencer for the DLFloat MAC datapath: clear, stream N pairs, drain, return result.
// Optional sticky NaN flag on err when DLMAC_NAN_STICKY_EN is defined.
module dlfloat_mac_seq
  import dlfloat_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             err,
  dlfloat_mac_seq_if.slave bus
);

  localparam int DLY_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  seq_state_e       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [DLF_W-1:0] mac_a_q, mac_a_d;
  logic [DLF_W-1:0] mac_b_q, mac_b_d;
  logic             mac_en_q, mac_en_d;
  logic [DLF_W-1:0] res_data_q, res_data_d;
  logic             op_ready;
  logic             mac_clr;
  logic             res_valid;

`ifdef DLMAC_NAN_STICKY_EN
  logic err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      dly_q      <= '0;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      mac_en_q   <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      dly_q      <= dly_d;
      mac_a_q    <= mac_a_d;
      mac_b_q    <= mac_b_d;
      mac_en_q   <= mac_en_d;
      res_data_q <= res_data_d;
    end
  end

`ifdef DLMAC_NAN_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    dly_d      = dly_q;
    mac_a_d    = mac_a_q;
    mac_b_d    = mac_b_q;
    mac_en_d   = 1'b0;
    res_data_d = res_data_q;
    op_ready   = 1'b0;
    mac_clr    = 1'b0;
    res_valid  = 1'b0;
`ifdef DLMAC_NAN_STICKY_EN
    err_d      = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = len;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        mac_clr = 1'b1;
`ifdef DLMAC_NAN_STICKY_EN
        err_d   = 1'b0;
`endif
        if (rem_q == '0) begin
          dly_d   = DLY_W'(MAC_LAT);
          state_d = DRAIN;
        end else begin
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        op_ready = 1'b1;
        if (bus.op_valid) begin
          mac_a_d  = bus.op_a;
          mac_b_d  = bus.op_b;
          mac_en_d = 1'b1;
          rem_d    = rem_q - 1'b1;
`ifdef DLMAC_NAN_STICKY_EN
          err_d    = err_q | dlf_is_nan(bus.op_a) | dlf_is_nan(bus.op_b);
`endif
          // Last pair: the drain countdown starts with the cycle its strobe is issued.
          if (rem_q == LEN_W'(1)) begin
            dly_d   = DLY_W'(MAC_LAT);
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (dly_q == '0) begin
`ifdef DLMAC_NAN_STICKY_EN
          res_data_d = err_q ? DLF_NAN : bus.mac_acc;
`else
          res_data_d = bus.mac_acc;
`endif
          state_d    = DONE;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end

      DONE: begin
        res_valid = 1'b1;
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign bus.op_ready  = op_ready;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.mac_clr   = mac_clr;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data_q;

`ifdef DLMAC_NAN_STICKY_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// Self-checking bench for dlfloat_mac_seq: table jobs, hand-written corner sequences
// and random jobs against a job-level reference sum. Honours DLMAC_NAN_STICKY_EN.
module tb_dlfloat_mac_seq;

  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 2;

`ifdef DLMAC_NAN_STICKY_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             err;

  dlfloat_mac_seq_if bus();

  dlfloat_mac_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .len   (len),
    .busy  (busy),
    .err   (err),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in datapath with the right pipeline shape (product reg, then accumulator reg).
  // Its "product" is a plain 16-bit sum a+b so results are easy to predict.
  logic [15:0] prod_q, acc_q;
  logic        pv_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      acc_q  <= '0;
      pv_q   <= 1'b0;
    end else begin
      pv_q <= bus.mac_en;
      if (bus.mac_en) prod_q <= bus.mac_a + bus.mac_b;
      if (bus.mac_clr) acc_q <= '0;
      else if (pv_q) acc_q <= acc_q + prod_q;
    end
  end
  assign bus.mac_acc = acc_q;

  // Strobe monitor, sampled mid-cycle.
  int en_cnt = 0, clr_cnt = 0, both_cnt = 0, streak = 0, last_streak = 0;
  always_ff @(negedge clk) begin
    en_cnt   <= en_cnt + int'(bus.mac_en);
    clr_cnt  <= clr_cnt + int'(bus.mac_clr);
    both_cnt <= both_cnt + int'(bus.mac_en & bus.mac_clr);
    if (bus.mac_en) begin
      streak <= streak + 1;
    end else if (streak != 0) begin
      last_streak <= streak;
      streak      <= 0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [15:0] pa[$];
  logic [15:0] pb[$];

  // mode: 0 = op_valid always high, 1 = 1,0,1,0 over ready cycles, 2 = random
  task automatic run_job(input string name, input int n, input int mode, input int hold,
                         input logic [15:0] exp_res, input logic exp_err);
    int en0, clr0, both0, idx, guard, k, lat;
    bit acc, seen_ready, early_drop;
    logic [15:0] held;
    en0 = en_cnt; clr0 = clr_cnt; both0 = both_cnt;
    start = 1'b1;
    len   = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;

    idx = 0; guard = 0; k = 0; seen_ready = 0; early_drop = 0;
    while (idx < n && guard < 1000) begin
      case (mode)
        0:       bus.op_valid = 1'b1;
        1:       bus.op_valid = (k % 2 == 0);
        default: bus.op_valid = 1'($urandom_range(0, 1));
      endcase
      bus.op_a = pa[idx];
      bus.op_b = pb[idx];
      if (seen_ready && !bus.op_ready) early_drop = 1;
      if (bus.op_ready) begin
        seen_ready = 1;
        k++;
      end
      acc = bus.op_valid && bus.op_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    bus.op_valid = 1'b0;
    chk({name, ":accepted"}, idx, n);
    if (n > 0) begin
      chk({name, ":ready_after_last"}, bus.op_ready, 1'b0);
      chk({name, ":ready_no_early_drop"}, early_drop, 1'b0);
    end

    lat = 0;
    while (!bus.res_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, ":res_valid"}, bus.res_valid, 1'b1);
    if (n == 0) chk({name, ":len0_latency_ok"}, (lat >= 1 && lat <= MAC_LAT + 3), 1);
    else        chk({name, ":latency"}, lat, MAC_LAT + 1);
    chk({name, ":res_data"}, bus.res_data, exp_res);
    chk({name, ":err"}, err, exp_err);
    chk({name, ":mac_en_count"}, en_cnt - en0, n);
    chk({name, ":mac_clr_count"}, clr_cnt - clr0, 1);
    chk({name, ":en_clr_overlap"}, both_cnt - both0, 0);
    chk({name, ":busy_done"}, busy, 1'b1);
    if (mode == 0 && n > 0) chk({name, ":en_consecutive"}, last_streak, n);

    // Stall the result; start pulses here must be ignored.
    held = bus.res_data;
    for (int h = 0; h < hold; h++) begin
      bus.res_ready = 1'b0;
      start = (h % 2 == 0);
      len   = LEN_W'(7);
      @(posedge clk); #1;
      chk({name, ":hold_valid"}, bus.res_valid, 1'b1);
      chk({name, ":hold_data"}, bus.res_data, held);
      chk({name, ":hold_busy"}, busy, 1'b1);
    end
    // Handshake with a simultaneous start, which must not launch a new job.
    bus.res_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    start = 1'b0;
    chk({name, ":busy_after_hs"}, busy, 1'b0);
    chk({name, ":valid_after_hs"}, bus.res_valid, 1'b0);
    @(posedge clk); #1;
    chk({name, ":still_idle"}, busy, 1'b0);
    $display("job %-14s len=%0d res_data=%04h expected=%04h err=%0b latency=%0d",
             name, n, held, exp_res, err, lat);
  endtask

  typedef struct {
    string       name;
    int          n;
    int          mode;
    int          hold;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_res;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // Stand-in product is a+b; result = n*(a+b) mod 2^16.
    vecs[0] = '{"len3_nobub",  3,   0, 0, 16'h3C00, 16'h3C00, 16'h6800};
    vecs[1] = '{"len4_toggle", 4,   1, 0, 16'h0001, 16'h0002, 16'h000C};
    vecs[2] = '{"len0",        0,   0, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{"len5_hold5",  5,   0, 5, 16'h4000, 16'h0001, 16'h4005};
    vecs[4] = '{"len1_toggle", 1,   1, 1, 16'h1234, 16'h0100, 16'h1334};
    vecs[5] = '{"len255_max",  255, 0, 0, 16'h0001, 16'h0000, 16'h00FF};

    rst_n = 1'b0;
    start = 1'b0;
    len   = '0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:busy",      busy, 1'b0);
    chk("rst:op_ready",  bus.op_ready, 1'b0);
    chk("rst:mac_en",    bus.mac_en, 1'b0);
    chk("rst:mac_clr",   bus.mac_clr, 1'b0);
    chk("rst:res_valid", bus.res_valid, 1'b0);
    chk("rst:err",       err, 1'b0);
    chk("rst:res_data",  bus.res_data, 16'h0000);
    chk("rst:mac_a",     bus.mac_a, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      pa.delete(); pb.delete();
      for (int i = 0; i < vecs[v].n; i++) begin
        pa.push_back(vecs[v].a);
        pb.push_back(vecs[v].b);
      end
      run_job(vecs[v].name, vecs[v].n, vecs[v].mode, vecs[v].hold, vecs[v].exp_res, 1'b0);
    end

    // NaN operand on the second pair.
    pa.delete(); pb.delete();
    pa.push_back(16'h3C00); pb.push_back(16'h3C00);
    pa.push_back(16'hFFFF); pb.push_back(16'h3C00);
    run_job("nan_second", 2, 0, 2, NAN_EN ? 16'hFFFF : 16'hB3FF, NAN_EN);

    // Reset in the middle of a 5-pair job, right after the second accept.
    pa.delete(); pb.delete();
    for (int i = 0; i < 5; i++) begin
      pa.push_back(16'h1111);
      pb.push_back(16'h2222);
    end
    start = 1'b1;
    len   = LEN_W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int idx, guard;
      bit acc;
      idx = 0; guard = 0;
      bus.op_valid = 1'b1;
      while (idx < 2 && guard < 20) begin
        bus.op_a = pa[idx];
        bus.op_b = pb[idx];
        acc = bus.op_ready;
        @(posedge clk); #1;
        if (acc) idx++;
        guard++;
      end
      bus.op_valid = 1'b0;
      chk("abort:accepted", idx, 2);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort:busy",      busy, 1'b0);
    chk("abort:op_ready",  bus.op_ready, 1'b0);
    chk("abort:mac_en",    bus.mac_en, 1'b0);
    chk("abort:mac_clr",   bus.mac_clr, 1'b0);
    chk("abort:mac_a",     bus.mac_a, 16'h0000);
    chk("abort:mac_b",     bus.mac_b, 16'h0000);
    chk("abort:res_valid", bus.res_valid, 1'b0);
    chk("abort:res_data",  bus.res_data, 16'h0000);
    chk("abort:err",       err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort:idle_after", busy, 1'b0);
    $display("job %-14s reset after 2 of 5 pairs", "abort_mid_job");
    pa.delete(); pb.delete();
    pa.push_back(16'h0101); pb.push_back(16'h0202);
    run_job("after_abort", 1, 0, 0, 16'h0303, 1'b0);

    // Random jobs: reference result is the modular sum of a+b over the job.
    for (int r = 0; r < 8; r++) begin
      int n;
      logic [15:0] sum, a, b;
      n = $urandom_range(1, 12);
      sum = '0;
      pa.delete(); pb.delete();
      for (int i = 0; i < n; i++) begin
        a = 16'($urandom);
        b = 16'($urandom);
        if (a == 16'hFFFF) a = 16'h0000;
        if (b == 16'hFFFF) b = 16'h0000;
        pa.push_back(a);
        pb.push_back(b);
        sum = sum + a + b;
      end
      run_job($sformatf("rand%0d", r), n, 2, $urandom_range(0, 3), sum, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
